// File: rtl/regs_file_fwd_pkg.sv
// Shared constants for the forwarding register file: control polarities,
// zero-register encodings and default geometry.
package regs_file_fwd_pkg;

  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned ADDR_W_DEF  = 5;
  localparam int unsigned NUM_RD_DEF  = 2;
  localparam int unsigned NUM_FWD_DEF = 2;

  localparam logic RstEnable = 1'b1;
  localparam logic WrtEnable = 1'b1;
  localparam logic RdEnable  = 1'b1;

  localparam int unsigned ZeroRegAddr = 0;
  localparam logic [63:0] ZeroRegData = 64'h0;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

endpackage

// File: rtl/regs_file_fwd_if.sv
// Bus bundle for the forwarding register file: read ports, WB write port,
// forwarding sources, issue marking and busy bits.
interface regs_file_fwd_if
  import regs_file_fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NUM_RD  = NUM_RD_DEF,
  parameter int unsigned NUM_FWD = NUM_FWD_DEF
);
  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic                        Stall_i_RegsFwd;
  logic                        Flush_i_RegsFwd;
  logic [NUM_RD-1:0]           RdEn_i_RegsFwd;
  logic [NUM_RD*ADDR_W-1:0]    Rd_Addr_i_RegsFwd;
  logic [NUM_RD*ADDR_W-1:0]    Rd_Addr_o_RegsFwd;
  logic [NUM_RD*DATA_W-1:0]    Rd_Data_o_RegsFwd;
  logic [NUM_RD-1:0]           Hazard_o_RegsFwd;
  logic                        WrEn_i_RegsFwd;
  logic [ADDR_W-1:0]           WrAddr_i_RegsFwd;
  logic [DATA_W-1:0]           WrData_i_RegsFwd;
  logic [NUM_FWD-1:0]          Fwd_Vld_i_RegsFwd;
  logic [NUM_FWD*ADDR_W-1:0]   Fwd_Addr_i_RegsFwd;
  logic [NUM_FWD*DATA_W-1:0]   Fwd_Data_i_RegsFwd;
  logic                        Iss_En_i_RegsFwd;
  logic [ADDR_W-1:0]           Iss_Addr_i_RegsFwd;
  logic [DEPTH-1:0]            Busy_o_RegsFwd;

  modport master (
    output Stall_i_RegsFwd, Flush_i_RegsFwd, RdEn_i_RegsFwd, Rd_Addr_i_RegsFwd,
           WrEn_i_RegsFwd, WrAddr_i_RegsFwd, WrData_i_RegsFwd,
           Fwd_Vld_i_RegsFwd, Fwd_Addr_i_RegsFwd, Fwd_Data_i_RegsFwd,
           Iss_En_i_RegsFwd, Iss_Addr_i_RegsFwd,
    input  Rd_Addr_o_RegsFwd, Rd_Data_o_RegsFwd, Hazard_o_RegsFwd, Busy_o_RegsFwd
  );

  modport slave (
    input  Stall_i_RegsFwd, Flush_i_RegsFwd, RdEn_i_RegsFwd, Rd_Addr_i_RegsFwd,
           WrEn_i_RegsFwd, WrAddr_i_RegsFwd, WrData_i_RegsFwd,
           Fwd_Vld_i_RegsFwd, Fwd_Addr_i_RegsFwd, Fwd_Data_i_RegsFwd,
           Iss_En_i_RegsFwd, Iss_Addr_i_RegsFwd,
    output Rd_Addr_o_RegsFwd, Rd_Data_o_RegsFwd, Hazard_o_RegsFwd, Busy_o_RegsFwd
  );

endinterface

// File: rtl/regs_file_fwd_mux.sv
// Per-read-port operand select: forwarding (youngest first), then WB
// write-through, then the array; flags reads of busy registers nobody supplies.
module regs_fwd_mux
  import regs_file_fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NUM_FWD = NUM_FWD_DEF
) (
  input  logic                      i_rd_en,
  input  logic [ADDR_W-1:0]         i_rd_addr,
  input  logic [NUM_FWD-1:0]        i_fwd_vld,
  input  logic [NUM_FWD*ADDR_W-1:0] i_fwd_addr,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
  input  logic                      i_wr_en,
  input  logic [ADDR_W-1:0]         i_wr_addr,
  input  logic [DATA_W-1:0]         i_wr_data,
  input  logic [DATA_W-1:0]         i_arr_data,
  input  logic                      i_busy,
  output logic [DATA_W-1:0]         o_data_c,
  output logic                      o_hazard_c
);

  logic              w_active;
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;
  logic              w_wb_hit;

  // Scan from oldest to youngest so the lowest index overrides
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = DATA_W'(ZeroRegData);
    for (int f = int'(NUM_FWD) - 1; f >= 0; f--) begin
      if (i_fwd_vld[f] && (i_fwd_addr[f*ADDR_W +: ADDR_W] == i_rd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = i_fwd_data[f*DATA_W +: DATA_W];
      end
    end
  end

  assign w_active = (i_rd_en == RdEnable) && (i_rd_addr != ADDR_W'(ZeroRegAddr));
  assign w_wb_hit = (i_wr_en == WrtEnable) && (i_wr_addr == i_rd_addr);

  always_comb begin
    o_data_c   = DATA_W'(ZeroRegData);
    o_hazard_c = 1'b0;
    if (w_active) begin
      if (w_fwd_hit) begin
        o_data_c = w_fwd_data;
      end else if (w_wb_hit) begin
        o_data_c = i_wr_data;
      end else begin
        o_data_c   = i_arr_data;
        o_hazard_c = i_busy;
      end
    end
  end

endmodule

// File: rtl/regs_file_fwd.sv
// Multi-port register file with forwarding, busy scoreboard and
// registered read outputs (stall holds, flush zeroes).
module regs_file_fwd
  import regs_file_fwd_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned NUM_RD  = NUM_RD_DEF,
  parameter int unsigned NUM_FWD = NUM_FWD_DEF
) (
  input  logic          clk_i_RegsFwd,
  input  logic          Rst_i_RegsFwd,
  regs_file_fwd_if.slave bus
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_busy;
  logic [NUM_RD*ADDR_W-1:0] r_rd_addr;
  logic [NUM_RD*DATA_W-1:0] r_rd_data;
  logic [NUM_RD-1:0]        r_hazard;

  logic                     w_wr_ok;
  logic                     w_iss_ok;
  logic [DEPTH-1:0]         w_busy_nxt;
  logic [ADDR_W-1:0]        w_rd_addr [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] w_sel_data;
  logic [NUM_RD-1:0]        w_sel_haz;

  assign w_wr_ok  = (bus.WrEn_i_RegsFwd == WrtEnable) &&
                    (bus.WrAddr_i_RegsFwd != ADDR_W'(ZeroRegAddr));
  assign w_iss_ok = bus.Iss_En_i_RegsFwd &&
                    (bus.Iss_Addr_i_RegsFwd != ADDR_W'(ZeroRegAddr));

  always_ff @(posedge clk_i_RegsFwd or posedge Rst_i_RegsFwd) begin
    if (Rst_i_RegsFwd == RstEnable) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= DATA_W'(ZeroRegData);
      end
    end else if (w_wr_ok) begin
      r_mem[bus.WrAddr_i_RegsFwd] <= bus.WrData_i_RegsFwd;
    end
  end

  // Issue is applied after WB clear so a same-cycle set wins
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok) begin
      w_busy_nxt[bus.WrAddr_i_RegsFwd] = 1'b0;
    end
    if (w_iss_ok) begin
      w_busy_nxt[bus.Iss_Addr_i_RegsFwd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i_RegsFwd or posedge Rst_i_RegsFwd) begin
    if (Rst_i_RegsFwd == RstEnable) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_port
    assign w_rd_addr[p] = bus.Rd_Addr_i_RegsFwd[p*ADDR_W +: ADDR_W];

    regs_fwd_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_FWD(NUM_FWD)
    ) u_mux (
      .i_rd_en   (bus.RdEn_i_RegsFwd[p]),
      .i_rd_addr (w_rd_addr[p]),
      .i_fwd_vld (bus.Fwd_Vld_i_RegsFwd),
      .i_fwd_addr(bus.Fwd_Addr_i_RegsFwd),
      .i_fwd_data(bus.Fwd_Data_i_RegsFwd),
      .i_wr_en   (bus.WrEn_i_RegsFwd),
      .i_wr_addr (bus.WrAddr_i_RegsFwd),
      .i_wr_data (bus.WrData_i_RegsFwd),
      .i_arr_data(r_mem[w_rd_addr[p]]),
      .i_busy    (r_busy[w_rd_addr[p]]),
      .o_data_c  (w_sel_data[p*DATA_W +: DATA_W]),
      .o_hazard_c(w_sel_haz[p])
    );
  end

  // Flush outranks stall; stall freezes only the read-side outputs
  always_ff @(posedge clk_i_RegsFwd or posedge Rst_i_RegsFwd) begin
    if (Rst_i_RegsFwd == RstEnable) begin
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_hazard  <= '0;
    end else if (bus.Flush_i_RegsFwd) begin
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_hazard  <= '0;
    end else if (!bus.Stall_i_RegsFwd) begin
      r_rd_addr <= bus.Rd_Addr_i_RegsFwd;
      r_rd_data <= w_sel_data;
      r_hazard  <= w_sel_haz;
    end
  end

  assign bus.Rd_Addr_o_RegsFwd = r_rd_addr;
  assign bus.Rd_Data_o_RegsFwd = r_rd_data;
  assign bus.Hazard_o_RegsFwd  = r_hazard;
  assign bus.Busy_o_RegsFwd    = r_busy;

endmodule

// File: tb/tb_regs_file_fwd.sv
// Scoreboard bench for regs_file_fwd: directed scenarios plus random traffic
// against an array-based reference model.
module tb_regs_file_fwd;
  import regs_file_fwd_pkg::*;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_RD  = 2;
  localparam int unsigned NUM_FWD = 2;
  localparam int unsigned DEPTH   = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regs_file_fwd_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD)) bus ();

  regs_file_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .NUM_FWD(NUM_FWD)) dut (
    .clk_i_RegsFwd(clk),
    .Rst_i_RegsFwd(rst),
    .bus          (bus)
  );

  typedef struct {
    logic [NUM_RD*ADDR_W-1:0] addr;
    logic [NUM_RD*DATA_W-1:0] data;
    logic [NUM_RD-1:0]        haz;
    logic [DEPTH-1:0]         busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference state
  logic [DATA_W-1:0]        m_mem  [DEPTH];
  logic                     m_busy [DEPTH];
  logic [NUM_RD*ADDR_W-1:0] m_addr;
  logic [NUM_RD*DATA_W-1:0] m_data;
  logic [NUM_RD-1:0]        m_haz;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_addr = '0;
    m_data = '0;
    m_haz  = '0;
  endfunction

  // Value a read of register a would see this cycle; hz reports an unsupplied busy read
  function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] a, output logic hz);
    hz = 1'b0;
    for (int f = 0; f < int'(NUM_FWD); f++)
      if (bus.Fwd_Vld_i_RegsFwd[f] && bus.Fwd_Addr_i_RegsFwd[f*ADDR_W +: ADDR_W] == a)
        return bus.Fwd_Data_i_RegsFwd[f*DATA_W +: DATA_W];
    if (bus.WrEn_i_RegsFwd && bus.WrAddr_i_RegsFwd == a)
      return bus.WrData_i_RegsFwd;
    hz = m_busy[a];
    return m_mem[a];
  endfunction

  function automatic void model_step();
    exp_t e;
    logic [ADDR_W-1:0] a;
    logic hz;
    logic [DATA_W-1:0] v;
    if (bus.Flush_i_RegsFwd) begin
      m_addr = '0; m_data = '0; m_haz = '0;
    end else if (!bus.Stall_i_RegsFwd) begin
      for (int p = 0; p < int'(NUM_RD); p++) begin
        a = bus.Rd_Addr_i_RegsFwd[p*ADDR_W +: ADDR_W];
        m_addr[p*ADDR_W +: ADDR_W] = a;
        v = '0; hz = 1'b0;
        if (bus.RdEn_i_RegsFwd[p] && a != 0) v = lookup(a, hz);
        m_data[p*DATA_W +: DATA_W] = v;
        m_haz[p] = hz;
      end
    end
    if (bus.WrEn_i_RegsFwd && bus.WrAddr_i_RegsFwd != 0) begin
      m_mem[bus.WrAddr_i_RegsFwd]  = bus.WrData_i_RegsFwd;
      m_busy[bus.WrAddr_i_RegsFwd] = 1'b0;
    end
    if (bus.Iss_En_i_RegsFwd && bus.Iss_Addr_i_RegsFwd != 0)
      m_busy[bus.Iss_Addr_i_RegsFwd] = 1'b1;
    e.addr = m_addr; e.data = m_data; e.haz = m_haz;
    for (int i = 0; i < int'(DEPTH); i++) e.busy[i] = m_busy[i];
    q.push_back(e);
  endfunction

  // Monitor: outputs update every edge, so one expectation is due per cycle
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst === 1'b0 && q.size() > 0) begin
      e = q.pop_front();
      chk("rd_addr", 64'(bus.Rd_Addr_o_RegsFwd), 64'(e.addr));
      chk("rd_data", 64'(bus.Rd_Data_o_RegsFwd), 64'(e.data));
      chk("hazard",  64'(bus.Hazard_o_RegsFwd),  64'(e.haz));
      chk("busy",    64'(bus.Busy_o_RegsFwd),    64'(e.busy));
    end
  end

  task automatic idle();
    bus.Stall_i_RegsFwd    = 1'b0;
    bus.Flush_i_RegsFwd    = 1'b0;
    bus.RdEn_i_RegsFwd     = '0;
    bus.Rd_Addr_i_RegsFwd  = '0;
    bus.WrEn_i_RegsFwd     = 1'b0;
    bus.WrAddr_i_RegsFwd   = '0;
    bus.WrData_i_RegsFwd   = '0;
    bus.Fwd_Vld_i_RegsFwd  = '0;
    bus.Fwd_Addr_i_RegsFwd = '0;
    bus.Fwd_Data_i_RegsFwd = '0;
    bus.Iss_En_i_RegsFwd   = 1'b0;
    bus.Iss_Addr_i_RegsFwd = '0;
  endtask

  task automatic rd(input int p, input logic [ADDR_W-1:0] a);
    bus.RdEn_i_RegsFwd[p] = 1'b1;
    bus.Rd_Addr_i_RegsFwd[p*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.WrEn_i_RegsFwd = 1'b1; bus.WrAddr_i_RegsFwd = a; bus.WrData_i_RegsFwd = d;
  endtask

  task automatic fwd(input int f, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.Fwd_Vld_i_RegsFwd[f] = 1'b1;
    bus.Fwd_Addr_i_RegsFwd[f*ADDR_W +: ADDR_W] = a;
    bus.Fwd_Data_i_RegsFwd[f*DATA_W +: DATA_W] = d;
  endtask

  task automatic iss(input logic [ADDR_W-1:0] a);
    bus.Iss_En_i_RegsFwd = 1'b1; bus.Iss_Addr_i_RegsFwd = a;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    bus.Stall_i_RegsFwd = ($urandom_range(0, 9) == 0);
    bus.Flush_i_RegsFwd = ($urandom_range(0, 19) == 0);
    bus.RdEn_i_RegsFwd  = NUM_RD'($urandom);
    for (int p = 0; p < int'(NUM_RD); p++)
      bus.Rd_Addr_i_RegsFwd[p*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
    bus.Fwd_Vld_i_RegsFwd = NUM_FWD'($urandom);
    for (int f = 0; f < int'(NUM_FWD); f++) begin
      bus.Fwd_Addr_i_RegsFwd[f*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 7));
      bus.Fwd_Data_i_RegsFwd[f*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    bus.WrEn_i_RegsFwd     = ($urandom_range(0, 1) == 0);
    bus.WrAddr_i_RegsFwd   = ADDR_W'($urandom_range(0, 7));
    bus.WrData_i_RegsFwd   = DATA_W'($urandom);
    bus.Iss_En_i_RegsFwd   = ($urandom_range(0, 2) == 0);
    bus.Iss_Addr_i_RegsFwd = ADDR_W'($urandom_range(0, 7));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    #1;
    chk("reset_rd_addr", 64'(bus.Rd_Addr_o_RegsFwd), 64'h0);
    chk("reset_rd_data", 64'(bus.Rd_Data_o_RegsFwd), 64'h0);
    chk("reset_hazard",  64'(bus.Hazard_o_RegsFwd),  64'h0);
    chk("reset_busy",    64'(bus.Busy_o_RegsFwd),    64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Write then read back a plain array entry
    idle(); wr(5, 32'hA5A5A5A5); cyc();
    idle(); rd(0, 5); cyc();

    // Forwarding priority: Fwd0 > Fwd1 > WB write-through
    idle(); wr(7, 32'h11); fwd(1, 7, 32'h22); fwd(0, 7, 32'h33); rd(0, 7); cyc();
    idle(); wr(7, 32'h11); fwd(1, 7, 32'h22); rd(0, 7); cyc();
    idle(); wr(7, 32'h11); rd(0, 7); cyc();

    // Register 0 ignores writes and forwarding
    idle(); wr(0, 32'hFFFFFFFF); fwd(0, 0, 32'h1234); iss(0); rd(0, 0); rd(1, 0); cyc();
    idle(); rd(0, 0); cyc();

    // Busy tracking and hazard
    idle(); iss(3); cyc();
    idle(); rd(0, 3); cyc();
    idle(); wr(3, 32'h9); cyc();
    idle(); rd(0, 3); cyc();
    idle(); iss(3); wr(3, 32'h5); rd(1, 3); cyc();
    idle(); rd(0, 3); cyc();
    idle(); wr(3, 32'h6); cyc();

    // Stall holds for 3 cycles while inputs move; flush beats stall
    idle(); rd(0, 5); rd(1, 7); cyc();
    for (int i = 0; i < 3; i++) begin
      idle(); bus.Stall_i_RegsFwd = 1'b1; rd(0, ADDR_W'(i + 1)); rd(1, ADDR_W'(i + 3));
      wr(ADDR_W'(i + 10), DATA_W'(32'h100 + i)); cyc();
    end
    idle(); bus.Stall_i_RegsFwd = 1'b1; bus.Flush_i_RegsFwd = 1'b1; rd(0, 5); cyc();
    idle(); rd(0, 10); rd(1, 12); cyc();

    // Asynchronous reset between edges
    idle(); wr(9, 32'hDEAD); iss(9); rd(0, 5); rd(1, 7); cyc();
    idle(); rd(0, 9); rd(1, 5); cyc();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rd_addr", 64'(bus.Rd_Addr_o_RegsFwd), 64'h0);
    chk("async_rst_rd_data", 64'(bus.Rd_Data_o_RegsFwd), 64'h0);
    chk("async_rst_hazard",  64'(bus.Hazard_o_RegsFwd),  64'h0);
    chk("async_rst_busy",    64'(bus.Busy_o_RegsFwd),    64'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(); rd(0, 5); rd(1, 9); wr(4, 32'h44); cyc();
    idle(); rd(0, 4); rd(1, 7); cyc();

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      cyc();
    end

    idle();
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
